jellyvl_cdc_input_filter: RTL and testbench



---
 rtl/jellyvl_cdc_input_filter.sv | 135 +++++++++++++
 tb/tb_jellyvl_cdc_input_filter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/jellyvl_cdc_input_filter.sv
// ---------------------------------------------------------------------------
// jellyvl_cdc_input_filter
//
// Multi-channel synchroniser and glitch filter for asynchronous level inputs
// (buttons, DIP switches, external status and interrupt lines).
//
// Each channel:
//   in_async -> SYNC_FF-deep synchroniser -> optional inversion -> stability
//   counter -> out_level, plus one-cycle out_rise / out_fall pulses.
//
// out_level only takes a new value after the synchronised level has differed
// from it for FILTER_CYCLES consecutive enabled (cke=1) cycles. Any return to
// the current level before that restarts the count, so short glitches never
// reach the output.
//
// Ports:
//   clk        sole clock
//   reset      synchronous, active-high reset (overrides cke)
//   cke        clock enable for the filter stage (synchroniser always runs)
//   in_async   [CHANNELS] asynchronous raw inputs
//   out_level  [CHANNELS] filtered level
//   out_rise   [CHANNELS] one-cycle pulse after out_level goes 0->1
//   out_fall   [CHANNELS] one-cycle pulse after out_level goes 1->0
//
// Parameters:
//   CHANNELS       number of independent channels (>=1)
//   SYNC_FF        synchroniser stages per channel (2..10)
//   FILTER_CYCLES  stable enabled cycles needed to accept a new level (>=1)
//   INIT_VALUE     reset value of the synchroniser stages and of out_level
//   INVERT         per-channel mask; set bit inverts the synchronised level
//   DEVICE         target device string; behaviour is the same for all values
// ---------------------------------------------------------------------------
module jellyvl_cdc_input_filter #(
  parameter int                  CHANNELS      = 4,
  parameter int                  SYNC_FF       = 3,
  parameter int                  FILTER_CYCLES = 16,
  parameter logic [CHANNELS-1:0] INIT_VALUE    = '0,
  parameter logic [CHANNELS-1:0] INVERT        = '0,
  parameter string               DEVICE        = "RTL"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cke,
  input  logic [CHANNELS-1:0] in_async,
  output logic [CHANNELS-1:0] out_level,
  output logic [CHANNELS-1:0] out_rise,
  output logic [CHANNELS-1:0] out_fall
);

  // Counter wide enough to hold FILTER_CYCLES; in practice it stops at
  // FILTER_CYCLES-1 and never wraps.
  localparam int            CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  // -------------------------------------------------------------------------
  // Synchroniser: free-running, independent of cke, so the metastability
  // settling chain is never stalled. Stage 0 is the only consumer of
  // in_async; the raw input never reaches combinational logic.
  // -------------------------------------------------------------------------
  (* ASYNC_REG = "TRUE" *) logic [CHANNELS-1:0] sync_ff [SYNC_FF];

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every stage samples the value its predecessor held before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_FF; i++) begin
        sync_ff[i] <= INIT_VALUE;
      end
    end else begin
      sync_ff[0] <= in_async;
      for (int i = 1; i < SYNC_FF; i++) begin
        sync_ff[i] <= sync_ff[i-1];
      end
    end
  end

  // Synchronised, polarity-corrected level seen by the filter.
  logic [CHANNELS-1:0] sync_level;
  assign sync_level = sync_ff[SYNC_FF-1] ^ INVERT;

  // -------------------------------------------------------------------------
  // Filter decode: which channels differ from their output, and which of
  // those complete their stability window on this edge.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] differ;
  logic [CHANNELS-1:0] accept;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    differ = '0;
    accept = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      differ[c] = sync_level[c] ^ out_level[c];
      accept[c] = cke && differ[c] && (cnt[c] == CNT_LAST);
    end
  end

  // -------------------------------------------------------------------------
  // Filter state: per-channel stability counter, filtered level and pulses.
  // Pulses default low each cycle, so they last exactly one cycle and are
  // always low after a cke=0 edge or a reset.
  // -------------------------------------------------------------------------
  // NOTE: the counters are a handful of flops, not a RAM, so they are reset
  // explicitly; a reset mid-count must discard all progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_level <= INIT_VALUE;
      out_rise  <= '0;
      out_fall  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
      end
    end else begin
      out_rise <= '0;
      out_fall <= '0;
      if (cke) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (!differ[c]) begin
            cnt[c] <= '0;
          end else if (accept[c]) begin
            out_level[c] <= sync_level[c];
            out_rise[c]  <= sync_level[c];
            out_fall[c]  <= ~sync_level[c];
            cnt[c]       <= '0;
          end else begin
            cnt[c] <= cnt[c] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jellyvl_cdc_input_filter.sv
// ---------------------------------------------------------------------------
// Directed testbench for jellyvl_cdc_input_filter.
//   dut_a : CHANNELS=3, SYNC_FF=2, FILTER_CYCLES=4, INIT_VALUE=0, INVERT=0
//   dut_b : same, INIT_VALUE=3'b001, INVERT=3'b001
//   dut_c : CHANNELS=1, SYNC_FF=2, FILTER_CYCLES=1
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// well away from the next edge.
// ---------------------------------------------------------------------------
module tb_jellyvl_cdc_input_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cke;
  logic [2:0] in_a, lvl_a, rise_a, fall_a;
  logic [2:0] in_b, lvl_b, rise_b, fall_b;
  logic       in_c, lvl_c, rise_c, fall_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jellyvl_cdc_input_filter #(
    .CHANNELS(3), .SYNC_FF(2), .FILTER_CYCLES(4),
    .INIT_VALUE(3'b000), .INVERT(3'b000), .DEVICE("RTL")
  ) dut_a (
    .clk(clk), .reset(reset), .cke(cke), .in_async(in_a),
    .out_level(lvl_a), .out_rise(rise_a), .out_fall(fall_a)
  );

  jellyvl_cdc_input_filter #(
    .CHANNELS(3), .SYNC_FF(2), .FILTER_CYCLES(4),
    .INIT_VALUE(3'b001), .INVERT(3'b001), .DEVICE("RTL")
  ) dut_b (
    .clk(clk), .reset(reset), .cke(cke), .in_async(in_b),
    .out_level(lvl_b), .out_rise(rise_b), .out_fall(fall_b)
  );

  jellyvl_cdc_input_filter #(
    .CHANNELS(1), .SYNC_FF(2), .FILTER_CYCLES(1),
    .INIT_VALUE(1'b0), .INVERT(1'b0), .DEVICE("RTL")
  ) dut_c (
    .clk(clk), .reset(reset), .cke(cke), .in_async(in_c),
    .out_level(lvl_c), .out_rise(rise_c), .out_fall(fall_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cke   = 1'b1;
    in_a  = 3'b111;
    in_b  = 3'b000;
    in_c  = 1'b0;

    // --- Reset release: inputs high throughout reset --------------------
    for (int j = 1; j <= 3; j++) begin
      step();
      check("rst_level", 32'(lvl_a), 32'h0);
      check("rst_rise",  32'(rise_a), 32'h0);
    end
    reset = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      step();
      check($sformatf("rel_level_e%0d", j), 32'(lvl_a), (j >= 6) ? 32'h7 : 32'h0);
      check($sformatf("rel_rise_e%0d", j),  32'(rise_a), (j == 6) ? 32'h7 : 32'h0);
    end

    // --- Glitch rejection on ch0 ------------------------------------------
    in_a = 3'b000;
    do_reset(2);
    in_a = 3'b001;
    for (int j = 1; j <= 10; j++) begin
      if (j == 4) in_a = 3'b000;
      step();
      check($sformatf("glitch_level_e%0d", j), 32'(lvl_a), 32'h0);
      check($sformatf("glitch_rise_e%0d", j),  32'(rise_a), 32'h0);
    end
    // Exactly FILTER_CYCLES of high level is accepted
    in_a = 3'b001;
    for (int j = 1; j <= 7; j++) begin
      if (j == 5) in_a = 3'b000;
      step();
      check($sformatf("hold4_level_e%0d", j), 32'(lvl_a), (j >= 6) ? 32'h1 : 32'h0);
      check($sformatf("hold4_rise_e%0d", j),  32'(rise_a), (j == 6) ? 32'h1 : 32'h0);
    end

    // --- Fall on ch1 while ch2 chatters -----------------------------------
    in_a = 3'b010;
    do_reset(2);
    repeat (8) step();
    check("fall_setup_level", 32'(lvl_a), 32'h2);
    in_a[1] = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      in_a[2] = ~(((j - 1) >> 1) & 1);
      step();
      check($sformatf("fall_level_e%0d", j), 32'(lvl_a), (j < 6) ? 32'h2 : 32'h0);
      check($sformatf("fall_pulse_e%0d", j), 32'(fall_a), (j == 6) ? 32'h2 : 32'h0);
      check($sformatf("fall_rise_e%0d", j),  32'(rise_a), 32'h0);
    end

    // --- cke gating: enabled only on odd edges ----------------------------
    in_a = 3'b000;
    do_reset(2);
    in_a = 3'b001;
    for (int j = 1; j <= 12; j++) begin
      cke = j[0];
      step();
      check($sformatf("cke_level_e%0d", j), 32'(lvl_a), (j >= 9) ? 32'h1 : 32'h0);
      check($sformatf("cke_rise_e%0d", j),  32'(rise_a), (j == 9) ? 32'h1 : 32'h0);
    end
    cke = 1'b1;

    // --- Reset mid-count --------------------------------------------------
    in_a = 3'b000;
    do_reset(2);
    in_a = 3'b001;
    repeat (5) step();            // ch0 counter now at 3
    check("midrst_pre_level", 32'(lvl_a), 32'h0);
    do_reset(1);
    check("midrst_level", 32'(lvl_a), 32'h0);
    check("midrst_rise",  32'(rise_a), 32'h0);
    for (int j = 1; j <= 7; j++) begin
      step();
      check($sformatf("midrst_level_e%0d", j), 32'(lvl_a), (j >= 6) ? 32'h1 : 32'h0);
      check($sformatf("midrst_rise_e%0d", j),  32'(rise_a), (j == 6) ? 32'h1 : 32'h0);
    end

    // --- INVERT / INIT_VALUE ----------------------------------------------
    in_b = 3'b000;
    do_reset(2);
    for (int j = 1; j <= 8; j++) begin
      step();
      check($sformatf("inv_idle_level_e%0d", j), 32'(lvl_b), 32'h1);
      check($sformatf("inv_idle_pulse_e%0d", j), 32'({rise_b, fall_b}), 32'h0);
    end
    in_b = 3'b001;
    for (int j = 1; j <= 7; j++) begin
      step();
      check($sformatf("inv_level_e%0d", j), 32'(lvl_b), (j >= 6) ? 32'h0 : 32'h1);
      check($sformatf("inv_fall_e%0d", j),  32'(fall_b), (j == 6) ? 32'h1 : 32'h0);
      check($sformatf("inv_rise_e%0d", j),  32'(rise_b), 32'h0);
    end

    // --- FILTER_CYCLES=1: one cycle behind the synchroniser ---------------
    in_c = 1'b0;
    do_reset(2);
    in_c = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      check($sformatf("fc1_up_level_e%0d", j), 32'(lvl_c), (j >= 3) ? 32'h1 : 32'h0);
      check($sformatf("fc1_up_rise_e%0d", j),  32'(rise_c), (j == 3) ? 32'h1 : 32'h0);
    end
    in_c = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      step();
      check($sformatf("fc1_dn_level_e%0d", j), 32'(lvl_c), (j >= 3) ? 32'h0 : 32'h1);
      check($sformatf("fc1_dn_fall_e%0d", j),  32'(fall_c), (j == 3) ? 32'h1 : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
